// File: rtl/wb_stream_writer_if.sv
// Bus bundle for wb_stream_writer: the inbound stream handshake plus the
// Wishbone write master signals. The writer uses the master view; whatever
// feeds the stream and answers the bus uses the slave view.
interface wb_stream_writer_if #(
  parameter int AW = 14,
  parameter int DW = 32
);
  localparam int MW = DW / 8;

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;

  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;
  logic [MW-1:0] wb_wmsk;
  logic          wb_we;
  logic          wb_cyc;
  logic          wb_ack;

  modport master (
    input  in_data, in_valid, wb_ack,
    output in_ready, wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc
  );

  modport slave (
    output in_data, in_valid, wb_ack,
    input  in_ready, wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc
  );
endinterface

// File: rtl/wb_stream_writer.sv
// Stream-to-Wishbone writer: takes cfg_len words from a valid/ready stream
// and writes them to consecutive word addresses starting at cfg_addr.
// Address and data are registered so they stay stable for the whole bus
// cycle. When an ack arrives and more words remain, the next word is
// accepted in the same cycle, so wb_cyc stays high (one word per two cycles).
module wb_stream_writer #(
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cfg_addr,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_start,
  output logic          stat_busy,
  output logic          stat_done,
  wb_stream_writer_if.master bus
);

  localparam int MW = DW / 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] addr;
  logic [LW-1:0] remaining;
  logic [DW-1:0] wdata;
  logic          cyc;

  logic last_word;
  logic ack_hit;
  logic take_word;

  assign last_word = (remaining == LW'(1));
  assign ack_hit   = (state == WRITE) && bus.wb_ack;
  assign take_word = bus.in_valid && bus.in_ready;

  // Transfer sequencing: load config, fetch a word, hold it on the bus until acked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      wdata     <= '0;
      cyc       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            addr      <= cfg_addr;
            remaining <= cfg_len;
            state     <= (cfg_len != '0) ? FETCH : DONE;
          end
        end
        FETCH: begin
          if (take_word) begin
            wdata <= bus.in_data;
            cyc   <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (ack_hit) begin
            addr      <= addr + AW'(1);
            remaining <= remaining - LW'(1);
            if (last_word) begin
              cyc   <= 1'b0;
              state <= DONE;
            end else if (take_word) begin
              wdata <= bus.in_data;
            end else begin
              cyc   <= 1'b0;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Ready in FETCH, or on the ack cycle when another word is still owed.
  assign bus.in_ready = (state == FETCH) || (ack_hit && !last_word);

  assign bus.wb_addr  = addr;
  assign bus.wb_wdata = wdata;
  assign bus.wb_wmsk  = {MW{1'b1}};
  assign bus.wb_we    = cyc;
  assign bus.wb_cyc   = cyc;

  assign stat_busy = (state != IDLE);
  assign stat_done = (state == DONE);

endmodule

// File: tb/tb_wb_stream_writer.sv
// Self-checking bench for wb_stream_writer: table of transfer configurations
// plus randomized transfers, checked against a word-list / memory model, and
// hand-written sequences for reset abort and a stray ack while idle.
module tb_wb_stream_writer;

  localparam int AW     = 14;
  localparam int DW     = 32;
  localparam int LW     = AW + 1;
  localparam int ASPACE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_addr;
  logic [LW-1:0] cfg_len;
  logic          cfg_start;
  logic          stat_busy;
  logic          stat_done;

  wb_stream_writer_if #(.AW(AW), .DW(DW)) bus ();

  wb_stream_writer #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_addr  (cfg_addr),
    .cfg_len   (cfg_len),
    .cfg_start (cfg_start),
    .stat_busy (stat_busy),
    .stat_done (stat_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    bit            gaps;
    int            ackMax;
    bit            midStart;
    bit            checkRate;
    logic [AW-1:0] expLast;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] src[$];
  int            srcIdx;
  logic [AW-1:0] logAddr[$];
  logic [DW-1:0] logData[$];
  int            ackCycles[$];
  logic [DW-1:0] mem [int];

  int            cycleNum = 0;
  int            doneCount, protoErr, stableErr, readyCount, cycCount;
  bit            gapMode;
  int            ackMax, ackDelay, waitCnt;
  bit            prevPending;
  logic [AW-1:0] prevAddr;
  logic [DW-1:0] prevData;
  bit            lastBusy;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic resetObservers();
    logAddr.delete();
    logData.delete();
    ackCycles.delete();
    doneCount   = 0;
    protoErr    = 0;
    stableErr   = 0;
    readyCount  = 0;
    cycCount    = 0;
    prevPending = 1'b0;
  endtask

  task automatic driveStream();
    if (srcIdx < src.size()) begin
      bus.in_valid = gapMode ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_data  = src[srcIdx];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
    end
  endtask

  // One clock: observe at the falling edge, then drive stream and slave after the rising edge.
  task automatic stepCycle();
    bit hs;
    bit ackHit;
    @(negedge clk);
    cycleNum++;
    hs     = bus.in_valid && bus.in_ready;
    ackHit = bus.wb_ack && bus.wb_cyc;
    if (ackHit) begin
      logAddr.push_back(bus.wb_addr);
      logData.push_back(bus.wb_wdata);
      mem[int'(bus.wb_addr)] = bus.wb_wdata;
      ackCycles.push_back(cycleNum);
    end
    if (prevPending && bus.wb_cyc && (bus.wb_addr !== prevAddr || bus.wb_wdata !== prevData))
      stableErr++;
    prevPending = bus.wb_cyc && !bus.wb_ack;
    prevAddr    = bus.wb_addr;
    prevData    = bus.wb_wdata;
    lastBusy    = stat_busy;
    if (stat_done) doneCount++;
    if (bus.in_ready) readyCount++;
    if (bus.wb_cyc) cycCount++;
    if (bus.wb_we !== bus.wb_cyc) protoErr++;
    if (bus.wb_wmsk !== 4'hF) protoErr++;
    if (bus.in_ready && bus.wb_cyc && !bus.wb_ack) protoErr++;
    if (bus.in_ready && !stat_busy) protoErr++;
    @(posedge clk);
    #1;
    if (hs) srcIdx++;
    driveStream();
    if (bus.wb_ack) begin
      bus.wb_ack = 1'b0;
      ackDelay   = $urandom_range(1, ackMax);
      waitCnt    = bus.wb_cyc ? 1 : 0;
    end else if (bus.wb_cyc) begin
      waitCnt++;
      if (waitCnt > ackDelay) bus.wb_ack = 1'b1;
    end else begin
      waitCnt = 0;
    end
  endtask

  task automatic prepTransfer(input vec_t v);
    resetObservers();
    gapMode  = v.gaps;
    ackMax   = v.ackMax;
    ackDelay = $urandom_range(1, ackMax);
    waitCnt  = 0;
    src.delete();
    for (int i = 0; i < v.len + 2; i++) src.push_back($urandom);
    srcIdx = 0;
    driveStream();
    cfg_addr  = v.addr;
    cfg_len   = LW'(v.len);
    cfg_start = 1'b1;
    stepCycle();
    cfg_start = 1'b0;
    cfg_addr  = AW'($urandom);
    cfg_len   = LW'($urandom_range(1, 9));
  endtask

  // Run one full transfer and compare everything the model predicts.
  task automatic applyStimulus(input vec_t v, input string tag);
    int n;
    int busyErr;
    int cycAtDone;
    int nw;
    prepTransfer(v);
    n       = 0;
    busyErr = 0;
    while (doneCount == 0 && n < 2000) begin
      if (v.midStart && n == 4) begin
        cfg_addr  = v.addr + AW'(100);
        cfg_len   = LW'(3);
        cfg_start = 1'b1;
      end
      stepCycle();
      cfg_start = 1'b0;
      if (!lastBusy) busyErr++;
      n++;
    end
    checkOutput({tag, "_done_seen"}, 64'(doneCount), 64'd1);
    cycAtDone = cycCount;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      if (k == 0) checkOutput({tag, "_busy_after"}, 64'(lastBusy), 64'd0);
    end
    checkOutput({tag, "_done_pulses"}, 64'(doneCount), 64'd1);
    checkOutput({tag, "_busy_during"}, 64'(busyErr), 64'd0);
    checkOutput({tag, "_no_cyc_after"}, 64'(cycCount - cycAtDone), 64'd0);
    checkOutput({tag, "_words_taken"}, 64'(srcIdx), 64'(v.len));
    checkOutput({tag, "_writes"}, 64'(logAddr.size()), 64'(v.len));
    checkOutput({tag, "_stable"}, 64'(stableErr), 64'd0);
    checkOutput({tag, "_proto"}, 64'(protoErr), 64'd0);
    nw = (logAddr.size() < v.len) ? logAddr.size() : v.len;
    for (int i = 0; i < nw; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), 64'(logAddr[i]), 64'((int'(v.addr) + i) % ASPACE));
      checkOutput($sformatf("%s_data%0d", tag, i), 64'(logData[i]), 64'(src[i]));
      checkOutput($sformatf("%s_mem%0d", tag, i), 64'(mem[(int'(v.addr) + i) % ASPACE]), 64'(src[i]));
    end
    if (v.len > 0 && logAddr.size() > 0) begin
      checkOutput({tag, "_last_addr"}, 64'(logAddr[logAddr.size() - 1]), 64'(v.expLast));
    end
    if (v.len == 0) begin
      checkOutput({tag, "_len0_ready"}, 64'(readyCount), 64'd0);
      checkOutput({tag, "_len0_cyc"}, 64'(cycCount), 64'd0);
      checkOutput({tag, "_len0_latency_ok"}, 64'(n >= 1 && n <= 2), 64'd1);
    end
    if (v.checkRate) begin
      for (int i = 1; i < ackCycles.size(); i++)
        checkOutput($sformatf("%s_rate%0d", tag, i), 64'(ackCycles[i] - ackCycles[i-1]), 64'd2);
    end
  endtask

  initial begin
    vec_t v;
    int   n;

    vecs[0] = '{addr: 14'h0010, len: 4,  gaps: 1'b0, ackMax: 1, midStart: 1'b0, checkRate: 1'b1, expLast: 14'h0013};
    vecs[1] = '{addr: 14'h0200, len: 0,  gaps: 1'b0, ackMax: 1, midStart: 1'b0, checkRate: 1'b0, expLast: 14'h0000};
    vecs[2] = '{addr: 14'h3FFE, len: 3,  gaps: 1'b0, ackMax: 1, midStart: 1'b0, checkRate: 1'b0, expLast: 14'h0000};
    vecs[3] = '{addr: 14'h0123, len: 16, gaps: 1'b1, ackMax: 3, midStart: 1'b0, checkRate: 1'b0, expLast: 14'h0132};
    vecs[4] = '{addr: 14'h1000, len: 6,  gaps: 1'b1, ackMax: 3, midStart: 1'b1, checkRate: 1'b0, expLast: 14'h1005};
    vecs[5] = '{addr: 14'h3FF8, len: 16, gaps: 1'b1, ackMax: 2, midStart: 1'b0, checkRate: 1'b0, expLast: 14'h0007};

    rst          = 1'b1;
    cfg_addr     = '0;
    cfg_len      = '0;
    cfg_start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wb_ack   = 1'b0;
    ackMax       = 1;
    ackDelay     = 1;
    waitCnt      = 0;
    gapMode      = 1'b0;
    srcIdx       = 0;
    resetObservers();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cyc", 64'(bus.wb_cyc), 64'd0);
    checkOutput("rst_we", 64'(bus.wb_we), 64'd0);
    checkOutput("rst_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rst_busy", 64'(stat_busy), 64'd0);
    checkOutput("rst_done", 64'(stat_done), 64'd0);
    checkOutput("rst_addr", 64'(bus.wb_addr), 64'd0);
    checkOutput("rst_wdata", 64'(bus.wb_wdata), 64'd0);
    rst = 1'b0;
    repeat (2) stepCycle();

    for (int r = 0; r < 6; r++) applyStimulus(vecs[r], $sformatf("vec%0d", r));

    for (int r = 0; r < 4; r++) begin
      v.addr      = AW'($urandom);
      v.len       = $urandom_range(1, 20);
      v.gaps      = 1'b1;
      v.ackMax    = 3;
      v.midStart  = 1'b0;
      v.checkRate = 1'b0;
      v.expLast   = AW'((int'(v.addr) + v.len - 1) % ASPACE);
      applyStimulus(v, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a five-word transfer, after two words are written.
    v = '{addr: 14'h0100, len: 5, gaps: 1'b0, ackMax: 1, midStart: 1'b0, checkRate: 1'b0, expLast: 14'h0104};
    prepTransfer(v);
    n = 0;
    while (!(logAddr.size() == 2 && bus.wb_cyc) && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("abort_reached_write", 64'(logAddr.size() == 2 && bus.wb_cyc), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_cyc", 64'(bus.wb_cyc), 64'd0);
    checkOutput("abort_we", 64'(bus.wb_we), 64'd0);
    checkOutput("abort_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("abort_busy", 64'(stat_busy), 64'd0);
    checkOutput("abort_done", 64'(stat_done), 64'd0);
    checkOutput("abort_addr", 64'(bus.wb_addr), 64'd0);
    checkOutput("abort_wdata", 64'(bus.wb_wdata), 64'd0);
    stepCycle();
    rst = 1'b0;
    cycCount  = 0;
    doneCount = 0;
    repeat (4) stepCycle();
    checkOutput("abort_no_resume_cyc", 64'(cycCount), 64'd0);
    checkOutput("abort_no_resume_done", 64'(doneCount), 64'd0);

    v = '{addr: 14'h0200, len: 3, gaps: 1'b0, ackMax: 2, midStart: 1'b0, checkRate: 1'b0, expLast: 14'h0202};
    applyStimulus(v, "after_abort");

    // A stray ack while idle must not start a cycle or move the address.
    bus.wb_ack = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("stray_ack_cyc", 64'(bus.wb_cyc), 64'd0);
    checkOutput("stray_ack_addr", 64'(bus.wb_addr), 64'h0203);
    checkOutput("stray_ack_busy", 64'(stat_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
